hex_bcd_display_driver: RTL
===========================

Name: hex_bcd_display_driver

Overview:
- Downstream consumer of the HEX3..HEX0 Avalon PIO output word; drives the four seven-segment displays HEX3..HEX0 directly.
- Takes a binary value (bits [15:0] of the PIO word) and shows it in one of two forms:
  - decimal: iterative shift-add-3 (double-dabble) binary-to-BCD conversion;
  - raw hex: conversion bypassed.
- Applies optional leading-zero blanking and overflow indication, then registers the segment patterns.
- Lets software write plain numbers (e.g. ADSR parameter values) instead of segment codes.

Parameters:
- BIN_W, 16, width of binary input; decimal conversion takes BIN_W cycles.
- SEG_ACTIVE_LOW, 1, 1 = segment lit when bit is 0 (board default); 0 = active-high.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- bin_in  in  BIN_W  binary value (PIO out_port[15:0])
- mode_hex  in  1  1 = display raw hex nibbles; 0 = decimal
- blank_lz  in  1  1 = blank leading zero digits
- load  in  1  single-cycle strobe (tied to PIO write); sampled only in IDLE
- busy  out  1  high while a conversion is in progress
- done  out  1  one-cycle pulse when the hex outputs update
- overflow  out  1  last decimal value exceeded 9999
- hex0  out  7  rightmost digit segments, bit0=a … bit6=g
- hex1  out  7  digit 1 segments
- hex2  out  7  digit 2 segments
- hex3  out  7  leftmost digit segments

Behaviour:
- Reset (synchronous, highest priority, including over load):
  - hex0..hex3 all segments off (7'h7F active-low, 7'h00 active-high);
  - busy=0, done=0, overflow=0, state=IDLE.
- Reset mid-conversion aborts the conversion and blanks the displays.
- States: IDLE, CONVERT, ENCODE.
- IDLE: on load=1, capture bin_in, mode_hex and blank_lz; set busy=1.
  - mode_hex=1 → ENCODE, digit nibbles = captured bin_in[15:0].
  - mode_hex=0 → CONVERT; clear 16-bit BCD register; load iteration counter with BIN_W.
- CONVERT, one iteration per cycle:
  - each BCD nibble >= 5 gets +3;
  - then {bcd,bin} shifts left by 1;
  - counter decrements;
  - after BIN_W iterations → ENCODE.
  - Overflow = captured value > 9999, compared against the captured value, not the BCD carry.
- ENCODE, one cycle:
  - map nibbles to segment codes and register hex0..hex3;
  - update overflow (always 0 in hex mode);
  - done=1 for the following cycle; busy=0; → IDLE.
- Latency, load sampled at edge E0:
  - decimal: outputs update at edge E0+BIN_W+1 (E17 for the default);
  - hex: outputs update at E0+1.
  - done is high exactly during the cycle after the update edge.
- A new load may be accepted in the same cycle that done is high.
- load while busy is ignored; no queuing.
- hex outputs hold their previous values throughout a conversion (no flicker).
- Segment codes, active-high gfedcba:
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F
  - A=77 b=7C C=39 d=5E E=79 F=71
  - dash=40, blank=00
  - Active-low outputs are the bitwise inverse.
- Leading-zero blanking, when blank_lz=1: every zero digit above the most significant nonzero digit shows blank. hex0 is never blanked, so value 0 shows "0".
- Overflow (decimal only): all four digits show dash, overflow=1, blank_lz ignored.
- overflow holds until the next completed ENCODE or reset.

Test Plan:
- Reset asserted 2 cycles → hex3..hex0=7'h7F, busy=0, done=0, overflow=0.
- bin_in=1234, decimal, blank_lz=0, load pulse at E0 → busy high E0..E17; at E17 hex3..hex0 = 79,24,30,19; done high one cycle; overflow=0.
- bin_in=7, decimal, blank_lz=1 → hex3..hex1=7F, hex0=78. Then bin_in=0 → hex3..hex1=7F, hex0=40.
- bin_in=16'hBEEF, mode_hex=1 → at E1 hex3..hex0 = 03,06,06,0E; done at next cycle; overflow=0.
- bin_in=10000, decimal, blank_lz=1 → all digits 3F, overflow=1. Then bin_in=9999 → all 10, overflow=0.
- Load 1234; at E5 pulse load with 5678 → ignored, E17 shows 1234. Repeat 1234, assert reset at E8 → outputs 7F, busy=0, no done pulse; next load converts normally.

Source files
------------

// File: rtl/hex_bcd_display_driver.sv
// Drives four seven-segment digits from a binary word, either as raw hex nibbles
// or as decimal via an iterative double-dabble conversion, with blanking and overflow dashes.
module hex_bcd_display_driver #(
  parameter int BIN_W          = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [BIN_W-1:0] bin_in,
  input  logic             mode_hex,
  input  logic             blank_lz,
  input  logic             load,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [6:0]       hex0,
  output logic [6:0]       hex1,
  output logic [6:0]       hex2,
  output logic [6:0]       hex3
);

  localparam int CNT_W = $clog2(BIN_W + 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CONVERT = 2'd1;
  localparam logic [1:0] ST_ENCODE  = 2'd2;

  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'h0: seg_code = 7'h3F;
      4'h1: seg_code = 7'h06;
      4'h2: seg_code = 7'h5B;
      4'h3: seg_code = 7'h4F;
      4'h4: seg_code = 7'h66;
      4'h5: seg_code = 7'h6D;
      4'h6: seg_code = 7'h7D;
      4'h7: seg_code = 7'h07;
      4'h8: seg_code = 7'h7F;
      4'h9: seg_code = 7'h6F;
      4'hA: seg_code = 7'h77;
      4'hB: seg_code = 7'h7C;
      4'hC: seg_code = 7'h39;
      4'hD: seg_code = 7'h5E;
      4'hE: seg_code = 7'h79;
      default: seg_code = 7'h71;
    endcase
  endfunction

  function automatic logic [6:0] polarity(input logic [6:0] s);
    polarity = SEG_ACTIVE_LOW ? ~s : s;
  endfunction

  logic [1:0]       state_q, state_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [15:0]      bcd_q, bcd_d;
  logic [15:0]      bcd_adj;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_hex_q, mode_hex_d;
  logic             blank_lz_q, blank_lz_d;
  logic             ovf_cap_q, ovf_cap_d;
  logic             done_q, done_d;
  logic             overflow_q, overflow_d;
  logic [6:0]       hex0_q, hex0_d, hex1_q, hex1_d, hex2_q, hex2_d, hex3_q, hex3_d;
  logic             blank3, blank2, blank1;

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    mode_hex_d = mode_hex_q;
    blank_lz_d = blank_lz_q;
    ovf_cap_d  = ovf_cap_q;
    overflow_d = overflow_q;
    hex0_d     = hex0_q;
    hex1_d     = hex1_q;
    hex2_d     = hex2_q;
    hex3_d     = hex3_q;
    done_d     = 1'b0;
    bcd_adj    = bcd_q;
    blank3     = blank_lz_q && (bcd_q[15:12] == 4'd0);
    blank2     = blank3 && (bcd_q[11:8] == 4'd0);
    blank1     = blank2 && (bcd_q[7:4] == 4'd0);

    case (state_q)
      ST_IDLE: begin
        if (load) begin
          bin_d      = bin_in;
          mode_hex_d = mode_hex;
          blank_lz_d = blank_lz;
          // Overflow is judged on the captured value, not on BCD carry-out.
          ovf_cap_d  = !mode_hex && (32'(bin_in) > 32'd9999);
          if (mode_hex) begin
            bcd_d   = 16'(bin_in);
            state_d = ST_ENCODE;
          end else begin
            bcd_d   = 16'd0;
            cnt_d   = CNT_W'(BIN_W);
            state_d = ST_CONVERT;
          end
        end
      end
      ST_CONVERT: begin
        for (int i = 0; i < 4; i++) begin
          if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ST_ENCODE;
      end
      ST_ENCODE: begin
        if (ovf_cap_q) begin
          hex0_d = polarity(7'h40);
          hex1_d = polarity(7'h40);
          hex2_d = polarity(7'h40);
          hex3_d = polarity(7'h40);
        end else begin
          hex0_d = polarity(seg_code(bcd_q[3:0]));
          hex1_d = blank1 ? polarity(7'h00) : polarity(seg_code(bcd_q[7:4]));
          hex2_d = blank2 ? polarity(7'h00) : polarity(seg_code(bcd_q[11:8]));
          hex3_d = blank3 ? polarity(7'h00) : polarity(seg_code(bcd_q[15:12]));
        end
        overflow_d = ovf_cap_q;
        done_d     = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      mode_hex_q <= 1'b0;
      blank_lz_q <= 1'b0;
      ovf_cap_q  <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      hex0_q     <= SEG_OFF;
      hex1_q     <= SEG_OFF;
      hex2_q     <= SEG_OFF;
      hex3_q     <= SEG_OFF;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      mode_hex_q <= mode_hex_d;
      blank_lz_q <= blank_lz_d;
      ovf_cap_q  <= ovf_cap_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
      hex0_q     <= hex0_d;
      hex1_q     <= hex1_d;
      hex2_q     <= hex2_d;
      hex3_q     <= hex3_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign overflow = overflow_q;
  assign hex0     = hex0_q;
  assign hex1     = hex1_q;
  assign hex2     = hex2_q;
  assign hex3     = hex3_q;

endmodule
